// File: rtl/flappy_game_ctrl.sv
// FlappyBox round sequencer: IDLE -> PLAY -> HIT -> OVER, motion/flap gating,
// and BCD score / high score. Every output comes straight from a register.
module flappy_game_ctrl #(
   parameter int HIT_FRAMES   = 60,
   parameter int GRACE_FRAMES = 30
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_frame_tick,
   input  logic        i_btn_flap,
   input  logic        i_collision,
   input  logic        i_obstacle_pass,
   output logic [1:0]  o_state,
   output logic        o_game_init,
   output logic        o_move_en,
   output logic        o_flap_en,
   output logic [11:0] o_score,
   output logic [11:0] o_hi_score
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_HIT  = 2'd2,
      ST_OVER = 2'd3
   } state_t;

   localparam logic [7:0] C_HIT_FRAMES   = 8'(HIT_FRAMES);
   localparam logic [7:0] C_GRACE_FRAMES = 8'(GRACE_FRAMES);

   state_t      r_state;
   logic [7:0]  r_cnt;
   logic [11:0] r_score;
   logic [11:0] r_hi_score;
   logic        r_game_init;
   logic        r_move_en;
   logic        r_flap_en;

   logic [11:0] w_score_inc;
   logic        w_carry;
   logic        w_hit;

   // Ripple a +1 through the BCD digits; a carry out of the top digit means 999.
   always_comb begin
      w_score_inc = r_score;
      w_carry     = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if (w_carry) begin
            if (r_score[4*i +: 4] == 4'd9) begin
               w_score_inc[4*i +: 4] = 4'd0;
            end else begin
               w_score_inc[4*i +: 4] = r_score[4*i +: 4] + 4'd1;
               w_carry = 1'b0;
            end
         end
      end
   end

   // Collision only counts on a frame tick, once the grace window is spent.
   assign w_hit = i_frame_tick && i_collision && (r_cnt == 8'd0);

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state     <= ST_IDLE;
         r_cnt       <= 8'd0;
         r_score     <= 12'h000;
         r_hi_score  <= 12'h000;
         r_game_init <= 1'b0;
         r_move_en   <= 1'b0;
         r_flap_en   <= 1'b0;
      end else begin
         r_game_init <= 1'b0;
         r_move_en   <= 1'b0;
         r_flap_en   <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_btn_flap) begin
                  r_state     <= ST_PLAY;
                  r_game_init <= 1'b1;
                  r_score     <= 12'h000;
                  r_cnt       <= C_GRACE_FRAMES;
               end
            end
            ST_PLAY: begin
               if (w_hit) begin
                  r_state <= ST_HIT;
                  r_cnt   <= C_HIT_FRAMES;
               end else begin
                  if (i_frame_tick) begin
                     r_move_en <= 1'b1;
                     if (r_cnt != 8'd0)
                        r_cnt <= r_cnt - 8'd1;
                  end
                  if (i_btn_flap)
                     r_flap_en <= 1'b1;
                  if (i_obstacle_pass && !w_carry)
                     r_score <= w_score_inc;
               end
            end
            ST_HIT: begin
               if (i_frame_tick) begin
                  if (r_cnt <= 8'd1) begin
                     r_state <= ST_OVER;
                     if (r_score > r_hi_score)
                        r_hi_score <= r_score;
                  end else begin
                     r_cnt <= r_cnt - 8'd1;
                  end
               end
            end
            ST_OVER: begin
               if (i_btn_flap)
                  r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_state     = r_state;
   assign o_game_init = r_game_init;
   assign o_move_en   = r_move_en;
   assign o_flap_en   = r_flap_en;
   assign o_score     = r_score;
   assign o_hi_score  = r_hi_score;

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// Scoreboard bench for flappy_game_ctrl: each driven cycle pushes the expected
// outputs from a decimal reference model; the result is popped after the edge.
module tb_flappy_game_ctrl;

   localparam int HITF   = 60;
   localparam int GRACEF = 30;

   typedef struct packed {
      logic [1:0]  st;
      logic        init;
      logic        move;
      logic        flap;
      logic [11:0] sc;
      logic [11:0] hi;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        tick, btn, col, pass;
   logic [1:0]  st;
   logic        init, move, flap;
   logic [11:0] sc, hi;

   exp_t q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   move_cnt = 0;
   int   m_state, m_cnt, m_score, m_hi;

   always #5 clk = ~clk;

   flappy_game_ctrl #(.HIT_FRAMES(HITF), .GRACE_FRAMES(GRACEF)) dut (
      .i_clk(clk), .i_reset(rst), .i_frame_tick(tick), .i_btn_flap(btn),
      .i_collision(col), .i_obstacle_pass(pass), .o_state(st),
      .o_game_init(init), .o_move_en(move), .o_flap_en(flap),
      .o_score(sc), .o_hi_score(hi)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [11:0] to_bcd(input int v);
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   task automatic model_reset();
      m_state = 0; m_cnt = 0; m_score = 0; m_hi = 0;
   endtask

   task automatic step(input logic t, input logic b, input logic c, input logic p);
      exp_t e;
      tick = t; btn = b; col = c; pass = p;
      e = '0;
      case (m_state)
         0: if (b) begin m_state = 1; e.init = 1'b1; m_score = 0; m_cnt = GRACEF; end
         1: begin
            if (t && c && m_cnt == 0) begin
               m_state = 2; m_cnt = HITF;
            end else begin
               if (t) begin e.move = 1'b1; if (m_cnt > 0) m_cnt--; end
               if (b) e.flap = 1'b1;
               if (p && m_score < 999) m_score++;
            end
         end
         2: if (t) begin
            if (m_cnt == 1) begin m_state = 3; if (m_score > m_hi) m_hi = m_score; end
            else m_cnt--;
         end
         default: if (b) m_state = 0;
      endcase
      e.st = 2'(m_state); e.sc = to_bcd(m_score); e.hi = to_bcd(m_hi);
      q.push_back(e);
      @(posedge clk); #1;
      e = q.pop_front();
      check_val("state", st, e.st);
      check_val("game_init", init, e.init);
      check_val("move_en", move, e.move);
      check_val("flap_en", flap, e.flap);
      check_val("score", sc, e.sc);
      check_val("hi_score", hi, e.hi);
      if (move) move_cnt++;
      $display("cyc t=%0t in{tick=%b btn=%b col=%b pass=%b} st=%0d init=%b mv=%b fl=%b sc=%h hi=%h",
               $time, t, b, c, p, st, init, move, flap, sc, hi);
   endtask

   initial begin
      rst = 1'b1; tick = 0; btn = 0; col = 0; pass = 0;
      model_reset();
      #2;
      check_val("rst_state", st, 2'd0);
      check_val("rst_score", sc, 12'h000);
      check_val("rst_hi", hi, 12'h000);
      check_val("rst_init", init, 1'b0);
      check_val("rst_move", move, 1'b0);
      check_val("rst_flap", flap, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      // Start and flap
      step(0, 0, 0, 1);
      check_val("idle_pass_ignored", sc, 12'h000);
      step(0, 1, 0, 0);
      check_val("start_state", st, 2'd1);
      check_val("start_init", init, 1'b1);
      check_val("start_noflap", flap, 1'b0);
      step(0, 0, 0, 0);
      check_val("init_one_cycle", init, 1'b0);
      step(0, 1, 0, 0);
      check_val("second_press_flap", flap, 1'b1);
      step(0, 0, 0, 0);
      check_val("flap_one_cycle", flap, 1'b0);

      // Seven passes, then the grace window under constant collision
      repeat (7) step(0, 0, 0, 1);
      check_val("score7", sc, 12'h007);
      move_cnt = 0;
      repeat (30) begin step(1, 0, 1, 0); step(0, 0, 1, 0); end
      check_val("grace_moves", move_cnt, 30);
      check_val("grace_state", st, 2'd1);
      step(1, 0, 1, 0);
      check_val("hit_state", st, 2'd2);
      check_val("hit_no_move", move, 1'b0);

      // Frozen playfield, then OVER after 60 ticks
      step(0, 1, 0, 0);
      check_val("hit_no_flap", flap, 1'b0);
      repeat (59) begin step(1, 0, 0, 0); step(0, 0, 0, 0); end
      check_val("hit_59_ticks", st, 2'd2);
      step(1, 0, 0, 0);
      check_val("over_state", st, 2'd3);
      check_val("over_hi", hi, 12'h007);
      step(0, 1, 0, 0);
      check_val("over_to_idle", st, 2'd0);
      check_val("over_score_held", sc, 12'h007);
      check_val("over_no_init", init, 1'b0);

      // Round 2: BCD carry, combined tick+flap, simultaneous events
      step(0, 1, 0, 0);
      check_val("r2_score_clear", sc, 12'h000);
      repeat (9) step(0, 0, 0, 1);
      check_val("bcd9", sc, 12'h009);
      step(0, 0, 0, 1);
      check_val("bcd10", sc, 12'h010);
      step(1, 1, 0, 0);
      check_val("both_move", move, 1'b1);
      check_val("both_flap", flap, 1'b1);
      repeat (29) step(1, 0, 0, 0);
      step(1, 1, 1, 1);
      check_val("simul_state", st, 2'd2);
      check_val("simul_score", sc, 12'h010);
      check_val("simul_flap", flap, 1'b0);
      repeat (3) step(1, 0, 0, 0);

      // Asynchronous reset between edges during HIT
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check_val("async_state", st, 2'd0);
      check_val("async_hi", hi, 12'h000);
      check_val("async_score", sc, 12'h000);
      @(negedge clk);
      rst = 1'b0;

      // Round 3: saturation at 999
      step(0, 1, 0, 0);
      repeat (999) step(0, 0, 0, 1);
      check_val("sat999", sc, 12'h999);
      step(0, 0, 0, 1);
      check_val("sat_hold", sc, 12'h999);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/flappy_game_ctrl.md
# flappy_game_ctrl

Game-flow controller for FlappyBox. It sits between the frame-rate tick, the flap button, and the combinational player/obstacle collision checker. It sequences each round through IDLE, PLAY, HIT and OVER, gates player and obstacle motion, and keeps a BCD score and high score for the display path. All outputs are registered.

## Interface
- `HIT_FRAMES`, default 60: frames the playfield stays frozen after a hit, before entering OVER.
- `GRACE_FRAMES`, default 30: frames after PLAY entry during which `collision` is ignored.
- `clk`  in  1: system clock.
- `reset`  in  1: asynchronous, active-high reset.
- `frame_tick`  in  1: one-`clk` pulse per video frame, ~60 Hz.
- `btn_flap`  in  1: debounced, synchronized one-`clk` pulse per button press.
- `collision`  in  1: level from the collision checker (floor or any obstacle).
- `obstacle_pass`  in  1: one-`clk` pulse when an obstacle's trailing edge passes the player x.
- `state`  out  2: IDLE=0, PLAY=1, HIT=2, OVER=3.
- `game_init`  out  1: one-cycle pulse that reinitialises player and obstacle positions.
- `move_en`  out  1: one-cycle motion strobe for player/obstacle updaters.
- `flap_en`  out  1: one-cycle flap command to the player physics block.
- `score`  out  12: 3-digit BCD score; [11:8] is hundreds.
- `hi_score`  out  12: 3-digit BCD best score since reset.

## Operation
- **Reset (async):**
  - `state` = IDLE; `score` = 0; `hi_score` = 0.
  - `game_init`, `move_en`, `flap_en` = 0.
  - Frame counter = 0.
- **IDLE:**
  - No motion.
  - `btn_flap` moves to PLAY, pulses `game_init`, clears `score`, and loads the grace counter with GRACE_FRAMES.
  - That first press does not generate `flap_en`.
- **PLAY:**
  - Each `frame_tick` produces `move_en` and decrements the grace counter, saturating at 0.
  - Each `btn_flap` produces `flap_en`.
  - Each `obstacle_pass` increments `score` in BCD, saturating at 999.
  - `collision` is sampled only on `frame_tick` cycles. This avoids mid-update glitches while positions change.
  - If `collision`=1 on a `frame_tick` with grace counter = 0: go to HIT, load the frame counter with HIT_FRAMES, and suppress `move_en` for that tick.
- **HIT:**
  - No `move_en` and no `flap_en`; the playfield is frozen.
  - The frame counter decrements per `frame_tick`.
  - When a `frame_tick` arrives with the counter at 1: go to OVER and load `hi_score` = `score` if `score` > `hi_score` (BCD compare equals binary compare).
- **OVER:**
  - The first `btn_flap` goes to IDLE, with no `game_init` and no `flap_en`.
  - `score` holds until the next PLAY entry.
- **Simultaneous events:**
  - Collision-triggered HIT wins over `obstacle_pass` on the same cycle: no increment.
  - Collision-triggered HIT wins over `btn_flap` on the same cycle: no `flap_en`.
  - `btn_flap` and `frame_tick` together in PLAY give both `flap_en` and `move_en`.
- **Reset mid-round:** returns to IDLE immediately from any state. `hi_score` is also cleared.
- **Counter widths:**
  - The frame/grace counter is 8 bits.
  - GRACE_FRAMES and HIT_FRAMES are in the range 1..255.

## Timing
- All outputs change on the `clk` edge after the causing input cycle: one cycle latency.
- The `state` transition and its pulses (`game_init`, the `score` clear) appear on the same edge.
- `move_en` and `flap_en` are single-cycle. They are never asserted outside PLAY.
- `score` updates one cycle after `obstacle_pass`.
- `hi_score` updates on the same edge that `state` becomes OVER.
- **Collision path:**
  - Collision detected on a tick at cycle t: `state`=HIT at t+1.
  - OVER is reached HIT_FRAMES `frame_tick`s later, counting the tick at t as the trigger, not the first counted frame.

## Test plan
- **Start and flap:** reset, then `btn_flap` -> `state`=1, `game_init` high for exactly 1 cycle, `score`=0x000, `flap_en`=0. A second press -> `flap_en` pulse 1 cycle later.
- **Grace window:** enter PLAY, hold `collision`=1 for 30 ticks -> `state` stays 1 and 30 `move_en` pulses occur. On the 31st tick -> `state`=2, no `move_en` on that tick.
- **Hit and high score:** score 7 passes, then collide -> after 60 further ticks `state`=3, `hi_score`=0x007. Next press -> `state`=0, `score` still 0x007.
- **BCD and saturation:** 9 passes -> 0x009; 10th -> 0x010. 999 passes -> 0x999; a further pass -> 0x999.
- **Simultaneous events:** `obstacle_pass`, `btn_flap` and `collision` on the same `frame_tick` after grace -> `state`=2, `score` unchanged, no `flap_en`.
- **Reset mid-HIT:** assert `reset` asynchronously between edges -> outputs clear immediately: `state`=0, `hi_score`=0.
